// File: rtl/pic_pkg.sv
// Shared encodings for the 8259 bus-side command sequencer.
package pic_pkg;

  // Command word index presented with each commit pulse.
  localparam logic [2:0] CW_ICW1 = 3'd0;
  localparam logic [2:0] CW_ICW2 = 3'd1;
  localparam logic [2:0] CW_ICW3 = 3'd2;
  localparam logic [2:0] CW_ICW4 = 3'd3;
  localparam logic [2:0] CW_OCW1 = 3'd4;
  localparam logic [2:0] CW_OCW2 = 3'd5;
  localparam logic [2:0] CW_OCW3 = 3'd6;
  localparam logic [2:0] CW_NONE = 3'd7;

  // Register-read select codes.
  localparam logic [2:0] RS_IRR  = 3'b001;
  localparam logic [2:0] RS_ISR  = 3'b101;
  localparam logic [2:0] RS_IMR  = 3'b011;
  localparam logic [2:0] RS_IDLE = 3'b000;

  // Initialisation sequence position.
  typedef enum logic [2:0] {
    StWaitIcw1,
    StIcw2,
    StIcw3,
    StIcw4,
    StReady
  } pic_state_e;

endpackage

// File: rtl/pic_strobe_capture.sv
// Samples the CPU strobes, captures write content and flags write completion.
module pic_strobe_capture (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] data_in,
  output logic       wr_act_q,
  output logic       rd_act_q,
  output logic       rd_a0_q,
  output logic       commit,
  output logic       cap_a0,
  output logic [7:0] cap_data
);

  logic wr_act;
  logic rd_act;

  assign wr_act = ~cs_n & ~wr_n;
  assign rd_act = ~cs_n & ~rd_n;

  // Falling edge of the sampled write strobe; cs_n rising alone also ends a write.
  assign commit = wr_act_q & ~wr_act;

  // Strobe history plus the most recent address/data seen during a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_act_q <= 1'b0;
      rd_act_q <= 1'b0;
      rd_a0_q  <= 1'b0;
      cap_a0   <= 1'b0;
      cap_data <= 8'h00;
    end else begin
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
      rd_a0_q  <= a0;
      if (wr_act) begin
        cap_a0   <= a0;
        cap_data <= data_in;
      end
    end
  end

endmodule

// File: rtl/pic_command_sequencer.sv
// Classifies completed CPU writes as ICW1-4 / OCW1-3 and drives the read select.
module pic_command_sequencer
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] data_in,
  output logic       cw_valid,
  output logic [2:0] cw_index,
  output logic [7:0] cw_data,
  output logic [2:0] read_sel,
  output logic       data_oe,
  output logic       init_done,
  output logic       sngl,
  output logic       ic4
);

  logic       wr_act_q;
  logic       rd_act_q;
  logic       rd_a0_q;
  logic       commit;
  logic       cap_a0;
  logic [7:0] cap_data;

  pic_strobe_capture u_capture (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .rd_n     (rd_n),
    .a0       (a0),
    .data_in  (data_in),
    .wr_act_q (wr_act_q),
    .rd_act_q (rd_act_q),
    .rd_a0_q  (rd_a0_q),
    .commit   (commit),
    .cap_a0   (cap_a0),
    .cap_data (cap_data)
  );

  pic_state_e state_q, state_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic       isr_sel_q, isr_sel_d;  // 1: a0=0 reads return ISR, else IRR
  logic [2:0] idx_d;
  logic       valid_d;
  logic       cw_valid_q;
  logic [2:0] cw_index_q;
  logic [7:0] cw_data_q;

  // Decode the committed write and advance the initialisation sequence.
  always_comb begin
    state_d   = state_q;
    sngl_d    = sngl_q;
    ic4_d     = ic4_q;
    isr_sel_d = isr_sel_q;
    idx_d     = CW_NONE;
    if (commit) begin
      if (!cap_a0 && cap_data[4]) begin
        // ICW1 restarts the sequence from any state.
        idx_d     = CW_ICW1;
        sngl_d    = cap_data[1];
        ic4_d     = cap_data[0];
        isr_sel_d = 1'b0;
        state_d   = StIcw2;
      end else if (cap_a0) begin
        case (state_q)
          StIcw2: begin
            idx_d = CW_ICW2;
            if (!sngl_q) begin
              state_d = StIcw3;
            end else if (ic4_q) begin
              state_d = StIcw4;
            end else begin
              state_d = StReady;
            end
          end
          StIcw3: begin
            idx_d   = CW_ICW3;
            state_d = ic4_q ? StIcw4 : StReady;
          end
          StIcw4: begin
            idx_d   = CW_ICW4;
            state_d = StReady;
          end
          StReady: idx_d = CW_OCW1;
          default: idx_d = CW_NONE;
        endcase
      end else if (state_q == StReady) begin
        if (cap_data[3]) begin
          idx_d = CW_OCW3;
          if (cap_data[1]) begin
            isr_sel_d = cap_data[0];
          end
        end else begin
          idx_d = CW_OCW2;
        end
      end
    end
  end

  assign valid_d = (idx_d != CW_NONE);

  // Sequence state, latched ICW1 bits and the registered command pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StWaitIcw1;
      sngl_q     <= 1'b0;
      ic4_q      <= 1'b0;
      isr_sel_q  <= 1'b0;
      cw_valid_q <= 1'b0;
      cw_index_q <= CW_NONE;
      cw_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      sngl_q     <= sngl_d;
      ic4_q      <= ic4_d;
      isr_sel_q  <= isr_sel_d;
      cw_valid_q <= valid_d;
      cw_index_q <= idx_d;
      if (valid_d) begin
        cw_data_q <= cap_data;
      end
    end
  end

  // Read select from the sampled strobes; an overlapping write suppresses the read.
  always_comb begin
    read_sel = RS_IDLE;
    if (rd_act_q && !wr_act_q) begin
      if (rd_a0_q) begin
        read_sel = RS_IMR;
      end else begin
        read_sel = isr_sel_q ? RS_ISR : RS_IRR;
      end
    end
  end

  assign data_oe   = rd_act_q & ~wr_act_q;
  assign cw_valid  = cw_valid_q;
  assign cw_index  = cw_index_q;
  assign cw_data   = cw_data_q;
  assign init_done = (state_q == StReady);
  assign sngl      = sngl_q;
  assign ic4       = ic4_q;

endmodule

// File: doc/pic_command_sequencer.md
# pic_command_sequencer

Bus-side front end of the 8259 model. It sits directly upstream of the control-logic block. It samples the CPU strobes (cs_n, wr_n, rd_n, a0, data_in), tracks the ICW1→ICW2→[ICW3]→[ICW4] initialisation sequence, and classifies every completed write as one of ICW1–4 or OCW1–3. It presents the result to control logic as a one-cycle command pulse with a command index and data byte, plus a registered register-read select.

## Interface
Parameters: none.

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces every register to its reset value
- cs_n  in  1  chip select, active-low, synchronous to clk
- wr_n  in  1  write strobe, active-low
- rd_n  in  1  read strobe, active-low
- a0  in  1  address bit
- data_in  in  8  CPU data bus
- cw_valid  out  1  one-cycle pulse: a command word is committed
- cw_index  out  3  0=ICW1, 1=ICW2, 2=ICW3, 3=ICW4, 4=OCW1, 5=OCW2, 6=OCW3, 7=none
- cw_data  out  8  byte of the committed command word
- read_sel  out  3  3'b001 IRR, 3'b101 ISR, 3'b011 IMR, 3'b000 idle
- data_oe  out  1  drive the data bus (read cycle in progress)
- init_done  out  1  high in state READY
- sngl  out  1  latched ICW1.D1
- ic4  out  1  latched ICW1.D0

## Operation
- wr_act = ~cs_n & ~wr_n, and rd_act = ~cs_n & ~rd_n, both registered every cycle.
- While wr_act is high, a0 and data_in are captured every cycle. The last captured values are the write's content.
- A write commits on the first cycle wr_act is sampled low after being high. Exactly one commit occurs per strobe, regardless of its length.
- Decode at commit:
  - a0=0 and D4=1 → ICW1, accepted in any state.
  - a0=1 in ICW2, ICW3 or ICW4 state → that ICW.
  - a0=1 in READY → OCW1.
  - a0=0, D4=0, D3=0 in READY → OCW2.
  - a0=0, D4=0, D3=1 in READY → OCW3.
  - Any other combination is ignored: no pulse, no state change.
- ICW1 side effects:
  - latch sngl=D1 and ic4=D0;
  - reset the read-register select to IRR;
  - go to state ICW2, even mid-sequence or from READY.
- State machine (WAIT_ICW1 at reset):
  - WAIT_ICW1 -ICW1→ ICW2.
  - ICW2 → ICW3 if !sngl; else ICW4 if ic4; else READY.
  - ICW3 → ICW4 if ic4, else READY.
  - ICW4 → READY.
  - READY stays in READY until ICW1.
- OCW3 with D1=1 latches the read-register select: D0=0 selects IRR, D0=1 selects ISR. With D1=0 the select is unchanged. The poll bit D2 is passed through in cw_data and not otherwise acted on.
- Reads:
  - rd_act with a0=1 → read_sel=IMR.
  - rd_act with a0=0 → the latched IRR or ISR code.
  - data_oe = rd_act, registered.
  - Reads are serviced in every state.
- If wr_act and rd_act are both asserted, the write takes precedence: read_sel=000 and data_oe=0.

## Timing
- Reset values:
  - cw_valid=0, cw_index=7, cw_data=0;
  - read_sel=000, data_oe=0;
  - init_done=0, sngl=0, ic4=0;
  - state WAIT_ICW1, read select IRR.
- Commit latency: wr_n rises before edge k, and edge k samples wr_act=0 with the previous sample 1. Then cw_valid, cw_index and cw_data are valid in cycle k→k+1 only.
- cw_index returns to 7 and cw_data holds its value when cw_valid is low.
- The state and init_done update on the same edge as cw_valid.
- Read latency: read_sel and data_oe follow rd_act with one cycle of latency and drop one cycle after rd_n or cs_n rises.
- cs_n rising while wr_n is still low counts as write completion.
- Back-to-back writes need at least one cycle with wr_act low between them.
- Reset asserted mid-write discards the write. No pulse is issued after reset is released.

## Structure
- pic_pkg holds:
  - the cw_index encodings (CW_ICW1..CW_OCW3, CW_NONE);
  - the read_sel encodings (RS_IRR, RS_ISR, RS_IMR, RS_IDLE);
  - the state enum.
- One sub-module, pic_strobe_capture. It registers wr_act/rd_act, captures a0 and data, and emits the commit pulse. The top module holds the decoder, the FSM and the read logic.

## Test plan
- Single mode, no ICW4: write a0=0 0x12, then a0=1 0x20. Expect pulses with index 0/0x12, then 1/0x20. init_done rises on the second edge. sngl=1, ic4=0.
- Cascade with ICW4: write 0x11, 0x40, 0x04, 0x01 (a0 = 0,1,1,1). Expect indices 0,1,2,3. init_done is set only after the fourth write.
- In READY, write a0=1 0xFB, a0=0 0x20, a0=0 0x0B. Expect indices 4, 5, 6. Then read with a0=0 → read_sel=101. Read with a0=1 → read_sel=011.
- Write ICW1 0x13 while in state ICW3. Expect index 0 and a return to state ICW2. The read select returns to IRR: a read with a0=0 gives 001.
- Hold wr_n low for 5 cycles with data changing 0x01→0x05. Expect exactly one pulse with cw_data=0x05. With rd_n and wr_n both low, read_sel stays 000.
- Assert reset mid-write, then release it. Expect no pulse, all outputs at their reset values, and OCW writes ignored until a new ICW1.
